fregfile_sb: RTL and testbench
==============================

FREGFILE_SB -- requirements
Module: fregfile_sb

Interface
REQ-001 SHALL have parameter SCALE, default 5, address width; depth = 2**SCALE.
REQ-002 SHALL have parameter WIDTH, default 32, data width (single-precision: sign [31], exp [30:23], frac [22:0]).
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clr  input  1  synchronous request to re-zero the file and drop all reservations.
REQ-006 SHALL have ports ra0/ra1/ra2  input  SCALE  read addresses.
REQ-007 SHALL have ports rd0/rd1/rd2  output  WIDTH  combinational read data.
REQ-008 SHALL have ports rb0/rb1/rb2  output  1  busy flag of the addressed register.
REQ-009 SHALL have ports we0, wa0, wd0  input  1/SCALE/WIDTH  write port 0 (FPU result).
REQ-010 SHALL have ports we1, wa1, wd1  input  1/SCALE/WIDTH  write port 1 (FLW load data).
REQ-011 SHALL have ports iss, iss_addr  input  1/SCALE  reserve a destination for an in-flight FPU op.
REQ-012 SHALL have port iss_ok  output  1  combinational: ready & ~busy[iss_addr].
REQ-013 SHALL have port ready  output  1  high when init sweep complete.

Function
REQ-014 SHALL implement a two-state FSM, INIT and RUN; INIT writes 0 to entry cnt each cycle, cnt from 0 to 2**SCALE-1, then enters RUN.
REQ-015 SHALL assert ready only in RUN; ready rises the cycle after cnt = 2**SCALE-1 is written (32 cycles after rst release for SCALE=5).
REQ-016 SHALL ignore we0, we1 and iss while in INIT.
REQ-017 SHALL drive rd0..rd2 = 0 and rb0..rb2 = 0 while ready is low.
REQ-018 SHALL, in RUN, write wd0 to wa0 when we0 and wd1 to wa1 when we1; if both address the same entry, port 0 wins.
REQ-019 SHALL include entry 0 as ordinary read/writable storage (no hardwired zero).
REQ-020 SHALL maintain one busy bit per entry: set on accepted iss (iss & iss_ok); cleared by we0 to that entry; we1 does not change busy.
REQ-021 SHALL ignore iss when iss_ok is low (no state change).
REQ-022 SHALL, on same-cycle accepted iss and we0 to the same entry, leave busy set (new reservation wins).
REQ-023 SHALL, on clr in any state, clear all busy bits, reset cnt to 0 and enter INIT next cycle; in-flight writes that cycle are discarded.
REQ-024 SHALL give rd read-during-write behaviour per REQ-030; rbN = busy[raN] except as modified by REQ-030.

Reset
REQ-025 SHALL, when rst is high at a rising edge, set state INIT, cnt 0, all busy bits 0; ready low the following cycle.
REQ-026 SHALL give rst priority over clr, we0, we1 and iss.
REQ-027 SHALL treat rst held high as holding INIT with cnt 0; the sweep starts on the first edge with rst low.

Configuration
REQ-028 SHALL compile write-forwarding in only when macro FREGFILE_SB_BYPASS_EN is defined.
REQ-029 SHALL, without FREGFILE_SB_BYPASS_EN, return stored contents on rdN and busy[raN] on rbN; new data visible the cycle after the write.
REQ-030 SHALL, with FREGFILE_SB_BYPASS_EN and ready high, return wd0 when we0 & wa0==raN, else wd1 when we1 & wa1==raN, else stored data; rbN forced 0 when we0 & wa0==raN.

Verification
REQ-031 SHALL test: rst 1 cycle, SCALE=5 -> ready low 32 cycles, high on cycle 33; all rd0 reads return 0x00000000.
REQ-032 SHALL test: we1, wa1=3, wd1=0x3F68F5C2 -> next cycle ra0=3 gives rd0=0x3F68F5C2; with BYPASS_EN same-cycle rd0=0x3F68F5C2.
REQ-033 SHALL test: iss, iss_addr=7 -> rb1=1 at ra1=7 and iss_ok=0 for 7; second iss to 7 ignored; we0, wa0=7, wd0=0x3F000000 -> busy clears, rd1=0x3F000000.
REQ-034 SHALL test: same cycle we0 (wd0=0x3E999999) and we1 (wd1=0x3E8F5C28) both to entry 2 -> entry 2 = 0x3E999999.
REQ-035 SHALL test: same cycle accepted iss and we0 to entry 9 -> busy[9]=1 afterwards.
REQ-036 SHALL test: clr mid-RUN with busy[4]=1 and entry 4=0x3F000000 -> ready low 32 cycles, then rb=0, rd=0 for entry 4.

Source files
------------

// File: rtl/fregfile_sb.sv
// Floating-point register file with per-entry busy scoreboard, 3 read / 2 write ports.
// Optional same-cycle write forwarding on reads when FREGFILE_SB_BYPASS_EN is defined.

module fregfile_sb_rd #(
  parameter int SCALE = 5,
  parameter int WIDTH = 32
) (
  input  logic [SCALE-1:0]              ra,
  input  logic [2**SCALE-1:0][WIDTH-1:0] mem,
  input  logic [2**SCALE-1:0]           busy,
  input  logic                          ready,
  input  logic                          we0,
  input  logic [SCALE-1:0]              wa0,
  input  logic [WIDTH-1:0]              wd0,
  input  logic                          we1,
  input  logic [SCALE-1:0]              wa1,
  input  logic [WIDTH-1:0]              wd1,
  output logic [WIDTH-1:0]              rd,
  output logic                          rb
);

`ifndef FREGFILE_SB_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ^{we0, wa0, wd0, we1, wa1, wd1};
`endif

  always_comb begin
    rd = '0;
    rb = 1'b0;
    if (ready) begin
      rd = mem[ra];
      rb = busy[ra];
`ifdef FREGFILE_SB_BYPASS_EN
      // a landing FPU result also retires the reservation it satisfies
      if (we0 && wa0 == ra) begin
        rd = wd0;
        rb = 1'b0;
      end else if (we1 && wa1 == ra) begin
        rd = wd1;
      end
`endif
    end
  end

endmodule

module fregfile_sb #(
  parameter int SCALE = 5,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [SCALE-1:0] ra0,
  input  logic [SCALE-1:0] ra1,
  input  logic [SCALE-1:0] ra2,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             rb0,
  output logic             rb1,
  output logic             rb2,
  input  logic             we0,
  input  logic [SCALE-1:0] wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [SCALE-1:0] wa1,
  input  logic [WIDTH-1:0] wd1,
  input  logic             iss,
  input  logic [SCALE-1:0] iss_addr,
  output logic             iss_ok,
  output logic             ready
);

  localparam int DEPTH = 2**SCALE;
  localparam int NRD   = 3;

  typedef enum logic {INIT, RUN} state_t;

  state_t                        state, state_nxt;
  logic [SCALE-1:0]              cnt, cnt_nxt;
  logic [DEPTH-1:0][WIDTH-1:0]   mem;
  logic [DEPTH-1:0]              busy;
  logic                          sweep, we0_ok, we1_ok, iss_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = INIT;
      cnt_nxt   = '0;
    end else begin
      case (state)
        INIT: begin
          cnt_nxt = cnt + 1'b1;
          if (&cnt) state_nxt = RUN;
        end
        default: ;
      endcase
    end
  end

  assign ready   = (state == RUN);
  assign iss_ok  = ready & ~busy[iss_addr];
  // clr discards everything in flight on the same edge
  assign sweep   = ~ready & ~clr;
  assign we0_ok  = ready & ~clr & we0;
  assign we1_ok  = ready & ~clr & we1;
  assign iss_acc = iss & iss_ok & ~clr;

  // port 0 assigned last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep) begin
        mem[cnt] <= '0;
      end else begin
        if (we1_ok) mem[wa1] <= wd1;
        if (we0_ok) mem[wa0] <= wd0;
      end
    end
  end

  // new reservation overrides a retiring one on the same entry
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      busy <= '0;
    end else begin
      if (we0_ok)  busy[wa0]      <= 1'b0;
      if (iss_acc) busy[iss_addr] <= 1'b1;
    end
  end

  logic [NRD-1:0][SCALE-1:0] ra_v;
  logic [NRD-1:0][WIDTH-1:0] rd_v;
  logic [NRD-1:0]            rb_v;

  assign ra_v = {ra2, ra1, ra0};

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    fregfile_sb_rd #(.SCALE(SCALE), .WIDTH(WIDTH)) u_rd (
      .ra    (ra_v[g]),
      .mem   (mem),
      .busy  (busy),
      .ready (ready),
      .we0   (we0),
      .wa0   (wa0),
      .wd0   (wd0),
      .we1   (we1),
      .wa1   (wa1),
      .wd1   (wd1),
      .rd    (rd_v[g]),
      .rb    (rb_v[g])
    );
  end

  assign rd0 = rd_v[0];
  assign rd1 = rd_v[1];
  assign rd2 = rd_v[2];
  assign rb0 = rb_v[0];
  assign rb1 = rb_v[1];
  assign rb2 = rb_v[2];

endmodule

// File: tb/tb_fregfile_sb.sv
// Scoreboard bench for fregfile_sb: reference model predicts each cycle's outputs,
// a monitor compares them mid-cycle. Honors FREGFILE_SB_BYPASS_EN like the design.

module tb_fregfile_sb;

  localparam int SCALE = 5;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2**SCALE;

  logic             clk = 1'b0;
  logic             rst, clr;
  logic [SCALE-1:0] ra0, ra1, ra2;
  logic [WIDTH-1:0] rd0, rd1, rd2;
  logic             rb0, rb1, rb2;
  logic             we0, we1, iss;
  logic [SCALE-1:0] wa0, wa1, iss_addr;
  logic [WIDTH-1:0] wd0, wd1;
  logic             iss_ok, ready;

  always #5 clk = ~clk;

  fregfile_sb #(.SCALE(SCALE), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .ra0(ra0), .ra1(ra1), .ra2(ra2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .rb0(rb0), .rb1(rb1), .rb2(rb2),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss(iss), .iss_addr(iss_addr),
    .iss_ok(iss_ok), .ready(ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] rd0, rd1, rd2;
    logic             rb0, rb1, rb2, iss_ok, ready;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference state: contents, reservations, sweep cycles still owed
  logic [WIDTH-1:0] m_mem  [DEPTH];
  bit               m_busy [DEPTH];
  int               init_left = DEPTH;
  bit               known = 0;

  function automatic logic [WIDTH-1:0] exp_rd(input logic [SCALE-1:0] a);
    if (init_left != 0) return '0;
`ifdef FREGFILE_SB_BYPASS_EN
    if (we0 && wa0 == a) return wd0;
    if (we1 && wa1 == a) return wd1;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_rb(input logic [SCALE-1:0] a);
    if (init_left != 0) return 1'b0;
`ifdef FREGFILE_SB_BYPASS_EN
    if (we0 && wa0 == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic void model_edge();
    bit acc;
    if (rst || clr) begin
      init_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
      if (rst) known = 1;
    end else if (init_left != 0) begin
      m_mem[DEPTH - init_left] = '0;
      init_left--;
    end else begin
      acc = iss && !m_busy[iss_addr];
      if (we1) m_mem[wa1] = wd1;
      if (we0) m_mem[wa0] = wd0;
      if (we0) m_busy[wa0] = 0;
      if (acc) m_busy[iss_addr] = 1;
    end
  endfunction

  task automatic step();
    exp_t e;
    if (known) begin
      e.rd0    = exp_rd(ra0);
      e.rd1    = exp_rd(ra1);
      e.rd2    = exp_rd(ra2);
      e.rb0    = exp_rb(ra0);
      e.rb1    = exp_rb(ra1);
      e.rb2    = exp_rb(ra2);
      e.ready  = (init_left == 0);
      e.iss_ok = (init_left == 0) && !m_busy[iss_addr];
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clr = 0; we0 = 0; we1 = 0; iss = 0;
  endtask

  function automatic logic [SCALE-1:0] raddr();
    return ($urandom % 2 == 0) ? SCALE'($urandom_range(0, 7)) : SCALE'($urandom);
  endfunction

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ready",  {31'b0, ready},  {31'b0, e.ready});
        chk("iss_ok", {31'b0, iss_ok}, {31'b0, e.iss_ok});
        chk("rd0", rd0, e.rd0);
        chk("rd1", rd1, e.rd1);
        chk("rd2", rd2, e.rd2);
        chk("rb0", {31'b0, rb0}, {31'b0, e.rb0});
        chk("rb1", {31'b0, rb1}, {31'b0, e.rb1});
        chk("rb2", {31'b0, rb2}, {31'b0, e.rb2});
      end
    end
  end

  initial begin
    rst = 1; idle();
    ra0 = '0; ra1 = '0; ra2 = '0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
    step();
    rst = 0;

    // init sweep: ready low 32 cycles, reads forced to zero
    for (int i = 0; i < 34; i++) begin
      ra0 = raddr(); ra1 = raddr(); ra2 = raddr();
      iss = 1; iss_addr = raddr(); we0 = 1; wa0 = raddr(); wd0 = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      ra0 = SCALE'(i); ra1 = SCALE'(DEPTH - 1 - i); ra2 = SCALE'(i ^ 5);
      step();
    end

    // load write then read back
    we1 = 1; wa1 = 5'd3; wd1 = 32'h3F68F5C2; ra0 = 5'd3; step();
    idle(); step();

    // reservation, refused re-issue, retirement
    iss = 1; iss_addr = 5'd7; ra1 = 5'd7; step();
    step();
    idle(); we0 = 1; wa0 = 5'd7; wd0 = 32'h3F000000; step();
    idle(); step();

    // dual write collision: port 0 wins
    we0 = 1; wa0 = 5'd2; wd0 = 32'h3E999999;
    we1 = 1; wa1 = 5'd2; wd1 = 32'h3E8F5C28; ra2 = 5'd2; step();
    idle(); step();

    // issue and retire on the same entry: reservation stays
    iss = 1; iss_addr = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h40490FDB; ra1 = 5'd9; step();
    idle(); step(); step();

    // clr mid-run with a live reservation and data in entry 4
    iss = 1; iss_addr = 5'd4; step();
    idle(); we1 = 1; wa1 = 5'd4; wd1 = 32'h3F000000; ra0 = 5'd4; ra1 = 5'd4; step();
    idle(); clr = 1; step();
    idle();
    for (int i = 0; i < 34; i++) step();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      we0 = ($urandom % 3 == 0); wa0 = raddr(); wd0 = $urandom;
      we1 = ($urandom % 3 == 0); wa1 = raddr(); wd1 = $urandom;
      iss = ($urandom % 3 == 0); iss_addr = raddr();
      ra0 = raddr(); ra1 = raddr(); ra2 = raddr();
      clr = ($urandom % 400 == 0);
      rst = ($urandom % 900 == 0);
      step();
    end
    rst = 0; idle();

    @(negedge clk); #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
